// File: rtl/timer_irq_source.sv
// Memory-mapped interval timer: TH reload, TL live counter, TCON control/pending.
// Optional prescaler register PSC at BASE+12 when TIMER_PRESCALE_EN is defined.
module timer_irq_source #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        irqout
);

  localparam logic [29:0] W_TH   = BASE_ADDR[31:2];
  localparam logic [29:0] W_TL   = BASE_ADDR[31:2] + 30'd1;
  localparam logic [29:0] W_TCON = BASE_ADDR[31:2] + 30'd2;

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic [2:0]  w_tcon_nxt;

  logic w_sel_th, w_sel_tl, w_sel_tcon;
  logic w_wr_th, w_wr_tl, w_wr_tcon;
  logic w_tick, w_ovf;
  logic w_unused;

  // Byte offset within a word is ignored.
  assign w_unused   = ^Address[1:0];

  assign w_sel_th   = (Address[31:2] == W_TH);
  assign w_sel_tl   = (Address[31:2] == W_TL);
  assign w_sel_tcon = (Address[31:2] == W_TCON);

  assign w_wr_th    = MemWrite && w_sel_th;
  assign w_wr_tl    = MemWrite && w_sel_tl;
  assign w_wr_tcon  = MemWrite && w_sel_tcon;

`ifdef TIMER_PRESCALE_EN
  localparam logic [29:0] W_PSC = BASE_ADDR[31:2] + 30'd3;

  logic [PRESCALE_W-1:0] r_psc;
  logic [PRESCALE_W-1:0] r_div;
  logic                  w_sel_psc;
  logic                  w_wr_psc;

  assign w_sel_psc = (Address[31:2] == W_PSC);
  assign w_wr_psc  = MemWrite && w_sel_psc;
  assign w_tick    = r_tcon[0] && (r_div == r_psc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_psc <= '0;
    end else if (w_wr_psc) begin
      r_psc <= WriteData[PRESCALE_W-1:0];
    end
  end

  // Divider restarts on PSC/TL writes so the first tick after a reload is a full period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_wr_psc || w_wr_tl) begin
      r_div <= '0;
    end else if (r_tcon[0]) begin
      if (r_div == r_psc) r_div <= '0;
      else                r_div <= r_div + PRESCALE_W'(1);
    end
  end
`else
  localparam int unused_prescale_w = PRESCALE_W;

  assign w_tick = r_tcon[0];
`endif

  // A TL write wins over the tick, so no overflow can happen on that edge.
  assign w_ovf = w_tick && !w_wr_tl && (&r_tl);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th <= '0;
    end else if (w_wr_th) begin
      r_th <= WriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tl <= '0;
    end else if (w_wr_tl) begin
      r_tl <= WriteData;
    end else if (w_ovf) begin
      r_tl <= r_th;
    end else if (w_tick) begin
      r_tl <= r_tl + 32'd1;
    end
  end

  // Overflow sets pending after the software write is applied, so a clear never hides a new irq.
  always_comb begin
    w_tcon_nxt = r_tcon;
    if (w_wr_tcon) w_tcon_nxt = WriteData[2:0];
    if (w_ovf && r_tcon[1]) w_tcon_nxt[2] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcon <= '0;
    end else begin
      r_tcon <= w_tcon_nxt;
    end
  end

  assign irqout = r_tcon[1] && r_tcon[2];

  always_comb begin
    ReadData = 32'h0;
    if (MemRead && !reset) begin
      if (w_sel_th)        ReadData = r_th;
      else if (w_sel_tl)   ReadData = r_tl;
      else if (w_sel_tcon) ReadData = {29'h0, r_tcon};
`ifdef TIMER_PRESCALE_EN
      else if (w_sel_psc)  ReadData = 32'(r_psc);
`endif
    end
  end

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed bench for timer_irq_source: reset, overflow/reload, masking, races, bus corner cases.
module tb_timer_irq_source;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH = BASE, A_TL = BASE + 32'd4, A_TCON = BASE + 32'd8;
  localparam logic [31:0] A_PSC = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData, ReadData;
  logic        irqout;
  logic [31:0] rv;

  int checks = 0;
  int errors = 0;

  timer_irq_source #(.BASE_ADDR(BASE), .PRESCALE_W(8)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .irqout(irqout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One bus write; consumes exactly one rising edge (the write edge).
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite = 1'b1; Address = a; WriteData = d;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  // Combinational read between edges; consumes no edge.
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    MemRead = 1'b1; Address = a;
    #1 d = ReadData;
    MemRead = 1'b0;
  endtask

  task automatic tk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    #1 chk("rst_irq", {31'h0, irqout}, 32'h0);
    rd(A_TCON, rv); chk("rst_rd", rv, 32'h0);
    @(negedge clk); reset = 1'b0;

    // Reset mid-count
    wr(A_TL, 32'h5); wr(A_TH, 32'h0); wr(A_TCON, 32'h7);
    chk("t1_irq_pre", {31'h0, irqout}, 32'h1);
    tk(1);
    rd(A_TL, rv); chk("t1_first_inc", rv, 32'h6);
    #1 reset = 1'b1;
    #1 chk("t1_irq_rst", {31'h0, irqout}, 32'h0);
    rd(A_TL, rv); chk("t1_rd_in_rst", rv, 32'h0);
    @(negedge clk); reset = 1'b0;
    rd(A_TL, rv);   chk("t1_tl", rv, 32'h0);
    rd(A_TCON, rv); chk("t1_tcon", rv, 32'h0);

    // Overflow and reload with irq enabled
    wr(A_TH, 32'hFFFF_FFFC); wr(A_TL, 32'hFFFF_FFFE); wr(A_TCON, 32'h3);
    rd(A_TL, rv); chk("t2_tl0", rv, 32'hFFFF_FFFE);
    tk(1);
    rd(A_TL, rv); chk("t2_tl1", rv, 32'hFFFF_FFFF);
    chk("t2_irq_before", {31'h0, irqout}, 32'h0);
    tk(1);
    rd(A_TL, rv);   chk("t2_reload", rv, 32'hFFFF_FFFC);
    rd(A_TCON, rv); chk("t2_tcon", rv, 32'h7);
    chk("t2_irq", {31'h0, irqout}, 32'h1);

    // Clear races a second overflow: pending survives
    tk(3);
    rd(A_TL, rv); chk("t4_tl_ff", rv, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h3);
    rd(A_TCON, rv); chk("t4_tcon", rv, 32'h7);
    rd(A_TL, rv);   chk("t4_tl", rv, 32'hFFFF_FFFC);
    chk("t4_irq", {31'h0, irqout}, 32'h1);
    wr(A_TCON, 32'h3);
    chk("t4_clear_irq", {31'h0, irqout}, 32'h0);

    // TL write beats the tick at FFFF_FFFF
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TL, 32'h10);
    rd(A_TL, rv);   chk("t5_tl", rv, 32'h10);
    rd(A_TCON, rv); chk("t5_tcon", rv, 32'h3);
    tk(1);
    rd(A_TL, rv);   chk("t5_inc", rv, 32'h11);

    // Masked overflow
    wr(A_TCON, 32'h0); wr(A_TL, 32'hFFFF_FFFE); wr(A_TCON, 32'h1);
    tk(2);
    rd(A_TL, rv);   chk("t3_reload", rv, 32'hFFFF_FFFC);
    rd(A_TCON, rv); chk("t3_tcon", rv, 32'h1);
    chk("t3_irq", {31'h0, irqout}, 32'h0);
    // Masked overflow leaves an existing pending untouched
    wr(A_TCON, 32'h5);
    tk(3);
    rd(A_TL, rv);   chk("t3_reload2", rv, 32'hFFFF_FFFC);
    rd(A_TCON, rv); chk("t3_pend_kept", rv, 32'h5);
    wr(A_TCON, 32'h7);
    chk("t3_unmask_irq", {31'h0, irqout}, 32'h1);

    // TH written on an overflow edge: old TH reloads, new TH next time
    wr(A_TCON, 32'h0); wr(A_TL, 32'hFFFF_FFFE); wr(A_TCON, 32'h1);
    tk(1);
    wr(A_TH, 32'h100);
    rd(A_TL, rv); chk("th_old", rv, 32'hFFFF_FFFC);
    tk(4);
    rd(A_TL, rv); chk("th_new", rv, 32'h100);

    // Read and write together return pre-write data
    wr(A_TCON, 32'h0);
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b1; Address = A_TH; WriteData = 32'h55;
    #1 chk("rw_pre", ReadData, 32'h100);
    @(posedge clk); #1;
    MemWrite = 1'b0;
    chk("rw_post", ReadData, 32'h55);
    MemRead = 1'b0;
    #1 chk("rd_idle", ReadData, 32'h0);

    // Bus decoding corners
    rd(BASE + 32'd1, rv); chk("byte_off", rv, 32'h55);
    wr(A_TCON, 32'hFFFF_FFFA);
    rd(A_TCON, rv); chk("tcon_hi0", rv, 32'h2);
    wr(A_TCON, 32'h0);
    rd(32'h0, rv); chk("out_of_blk", rv, 32'h0);
    rd(BASE + 32'd16, rv); chk("unmapped16", rv, 32'h0);
`ifdef TIMER_PRESCALE_EN
    wr(A_PSC, 32'h3); wr(A_TL, 32'h0); wr(A_TCON, 32'h1);
    tk(3);
    rd(A_TL, rv); chk("psc_tl0", rv, 32'h0);
    tk(1);
    rd(A_TL, rv); chk("psc_tl1", rv, 32'h1);
    tk(3);
    rd(A_TL, rv); chk("psc_tl1b", rv, 32'h1);
    tk(1);
    rd(A_TL, rv); chk("psc_tl2", rv, 32'h2);
    rd(A_PSC, rv); chk("psc_rd", rv, 32'h3);
`else
    wr(A_PSC, 32'h1234);
    rd(A_PSC, rv); chk("unmapped12", rv, 32'h0);
    rd(A_TH, rv);  chk("th_intact", rv, 32'h55);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
